mcu_mem_responder: RTL

- Responder (target) end of the cache-to-memory request interface.
- Samples mem_do_act and mem_we from the cache and returns a one-cycle mem_ack.
- Reads: returns a fixed-latency, critical-word-first, two-word burst on mem_datafrommem.
- Writes: commits one word to a synchronous backing SRAM.
- Owns the dma_mcu_access grant, so an external DMA engine can take the backing store while the CPU side is idle.

---
 rtl/mcu_mem_pkg.sv | 21 ++
 rtl/mcu_rd_sched.sv | 45 ++++
 rtl/mcu_mem_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mcu_mem_pkg.sv
// Shared types and constants for the cache-to-memory responder.
// Holds the responder state enum, burst/counter/word widths and default read latency.
package mcu_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    RD_WAIT,
    RD_B0,
    RD_B1,
    WR,
    DROP,
    HOLD
  } state_e;

  localparam int BURST_LEN  = 2;
  localparam int CNT_W      = 4;
  localparam int WORD_W     = 32;
  localparam int RD_LAT_DEF = 4;

endpackage

// File: rtl/mcu_rd_sched.sv
// Read scheduler: counts from the ACK cycle, fires the two backing-store read
// strobes and a one-cycle-late capture strobe for each burst beat.
// Ports: MCU_CLK, RST, act (read in flight), re0/re1 (strobe on A / A^1), cap.
module mcu_rd_sched
  import mcu_mem_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic MCU_CLK,
  input  logic RST,
  input  logic act,
  output logic re0,
  output logic re1,
  output logic cap
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_RE0 = CNT_W'(RD_LAT - 2);
  localparam logic [CNT_W-1:0] C_RE1 = CNT_W'(RD_LAT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cap_q, cap_d;

  always_comb begin
    cnt_d = '0;
    if (act) cnt_d = cnt_q + ONE;
    re0   = act && (cnt_q == C_RE0);
    re1   = act && (cnt_q == C_RE1);
    // store data lands one cycle after each strobe
    cap_d = re0 || re1;
  end

  always_ff @(posedge MCU_CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      cap_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cap_q <= cap_d;
    end
  end

  assign cap = cap_q;

endmodule

// File: rtl/mcu_mem_responder.sv
// Responder end of the cache-to-memory interface: acks requests, returns a
// critical-word-first 2-beat read burst, commits writes, arbitrates with DMA.
// Ports: mem_* cache side, dma_* grant/hold, bk_* backing SRAM.
// Optional stats counters enabled by MCU_MEM_RESPONDER_STATS_EN.
module mcu_mem_responder
  import mcu_mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int RD_LAT    = RD_LAT_DEF,
  parameter int BK_RD_LAT = 1
) (
  input  logic              MCU_CLK,
  input  logic              RST,
  input  logic [31:0]       mem_addr,
  input  logic              mem_we,
  input  logic              mem_do_act,
  input  logic [31:0]       mem_dataintomem,
  output logic              mem_ack,
  output logic [31:0]       mem_datafrommem,
  output logic              dma_mcu_access,
  input  logic              dma_hold,
  output logic              dma_held,
  output logic [ADDR_W-1:0] bk_addr,
  output logic              bk_re,
  output logic              bk_we,
  output logic [31:0]       bk_wdata,
`ifdef MCU_MEM_RESPONDER_STATS_EN
  output logic [15:0]       stat_rd,
  output logic [15:0]       stat_wr,
  input  logic              stat_clr,
`endif
  input  logic [31:0]       bk_rdata
);

  if (RD_LAT < 2 || RD_LAT > 15) begin : g_bad_lat
    $error("RD_LAT must be in 2..15");
  end
  if (BK_RD_LAT != 1) begin : g_bad_bk
    $error("BK_RD_LAT must be 1");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                held_q, held_d;
  logic                acc_q, acc_d;
  logic                rd_act, re0, re1, cap;
  logic [31-ADDR_W:0]  unused_addr;

  assign unused_addr = mem_addr[31:ADDR_W];

  mcu_rd_sched #(
    .RD_LAT(RD_LAT)
  ) u_sched (
    .MCU_CLK(MCU_CLK),
    .RST    (RST),
    .act    (rd_act),
    .re0    (re0),
    .re1    (re1),
    .cap    (cap)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mem_ack  = 1'b0;
    rd_act   = 1'b0;
    bk_re    = 1'b0;
    bk_we    = 1'b0;
    bk_addr  = '0;
    bk_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (mem_do_act && acc_q) state_d = ACK;
        else if (dma_hold)       state_d = HOLD;
      end
      ACK: begin
        mem_ack = 1'b1;
        addr_d  = mem_addr[ADDR_W-1:0];
        wdata_d = mem_dataintomem;
        rd_act  = !mem_we;
        state_d = mem_we ? WR : RD_WAIT;
      end
      RD_WAIT: begin
        rd_act = 1'b1;
        if (re1) state_d = RD_B0;
      end
      RD_B0: state_d = RD_B1;
      RD_B1: state_d = DROP;
      WR: begin
        bk_we    = 1'b1;
        bk_addr  = addr_q;
        bk_wdata = wdata_q;
        state_d  = DROP;
      end
      DROP: begin
        // refractory: a still-high request must not be re-acked
        if (!mem_do_act) state_d = IDLE;
      end
      HOLD: begin
        if (!dma_hold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // with RD_LAT=2 the first strobe is in ACK, before addr_q is loaded
    if (re0) begin
      bk_re   = 1'b1;
      bk_addr = (state_q == ACK) ? mem_addr[ADDR_W-1:0] : addr_q;
    end else if (re1) begin
      bk_re   = 1'b1;
      bk_addr = {addr_q[ADDR_W-1:1], ~addr_q[0]};
    end
    if (cap) rdata_d = bk_rdata;
    held_d = (state_q == HOLD) && dma_hold;
    acc_d  = !held_d;
  end

  always_ff @(posedge MCU_CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      held_q  <= 1'b0;
      acc_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      held_q  <= held_d;
      acc_q   <= acc_d;
    end
  end

  assign mem_datafrommem = rdata_q;
  assign dma_held        = held_q;
  assign dma_mcu_access  = acc_q;

`ifdef MCU_MEM_RESPONDER_STATS_EN
  logic [15:0] stat_rd_q, stat_rd_d;
  logic [15:0] stat_wr_q, stat_wr_d;

  always_comb begin
    stat_rd_d = stat_rd_q;
    stat_wr_d = stat_wr_q;
    if (stat_clr) begin
      stat_rd_d = '0;
      stat_wr_d = '0;
    end else if (state_q == ACK) begin
      if (mem_we) begin
        if (stat_wr_q != 16'hFFFF) stat_wr_d = stat_wr_q + 16'd1;
      end else begin
        if (stat_rd_q != 16'hFFFF) stat_rd_d = stat_rd_q + 16'd1;
      end
    end
  end

  always_ff @(posedge MCU_CLK or posedge RST) begin
    if (RST) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      stat_rd_q <= stat_rd_d;
      stat_wr_q <= stat_wr_d;
    end
  end

  assign stat_rd = stat_rd_q;
  assign stat_wr = stat_wr_q;
`endif

endmodule
